// File: rtl/cpu_trace_pkg.sv
// Shared state encoding and trace-entry layout for the cpu_v1 execution-trace recorder.
// Entry layout (default widths): {pc[41:32], ir[31:18], a[17:10], b[9:2], z[1], c[0]}.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int PC_W_DEF = 10;
  localparam int IR_W_DEF = 14;
  localparam int D_W_DEF  = 8;
  localparam int ENTRY_W  = PC_W_DEF + IR_W_DEF + 2 * D_W_DEF + 2;

  localparam int C_BIT  = 0;
  localparam int Z_BIT  = 1;
  localparam int B_LSB  = 2;
  localparam int A_LSB  = B_LSB + D_W_DEF;
  localparam int IR_LSB = A_LSB + D_W_DEF;
  localparam int PC_LSB = IR_LSB + IR_W_DEF;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with first-word-fall-through read: pop data is mem[rd_ptr] combinationally.
// One-cycle write latency; a push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter  int W     = 42,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_dat_o,
  output logic          push_ok_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          pop_ok;

  assign full      = (count_q == FULL_C);
  assign empty_o   = (count_q == '0);
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full || pop_ok);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // DEPTH is a power of two, so pointer wrap is plain binary rollover.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok_o && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok_o && pop_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Records one snapshot of the cpu_v1 architectural outputs per PC change into a FWFT FIFO.
// Entry visible one cycle after the event; drained via rd_valid/rd_ready, drops (sticky overflow) when full.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int PC_W  = PC_W_DEF,
  parameter  int IR_W  = IR_W_DEF,
  parameter  int D_W   = D_W_DEF,
  localparam int EW    = PC_W + IR_W + 2 * D_W + 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_in,
  input  logic [IR_W-1:0] ir_in,
  input  logic [D_W-1:0]  a_in,
  input  logic [D_W-1:0]  b_in,
  input  logic            z_in,
  input  logic            c_in,
  input  logic            arm,
  input  logic            stop,
  input  logic            trig_en,
  input  logic [PC_W-1:0] trig_pc,
  input  logic            one_shot,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [EW-1:0]   rd_data,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic [1:0]      state
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  trace_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic            pc_q_vld;
  logic [CW-1:0]   cap_cnt_q, cap_cnt_d, cap_next;
  logic            overflow_q, overflow_d;
  logic            pc_event, trig_hit, wr_req, arm_acc;
  logic            push_ok, fifo_empty;
  logic [EW-1:0]   entry;

  assign pc_event = pc_q_vld && (pc_in != pc_q);
  assign entry    = {pc_in, ir_in, a_in, b_in, z_in, c_in};
  assign cap_next = cap_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      pc_q_vld <= 1'b0;
    end else begin
      pc_q     <= pc_in;
      pc_q_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (arm_acc) state_d = trig_en ? ST_ARMED : ST_CAPTURE;
      ST_ARMED: begin
        if (stop)          state_d = ST_DONE;
        else if (trig_hit) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (stop || (one_shot && push_ok && cap_next == DEPTH_C)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stop wins over arm, and over a trigger landing in the same cycle.
  always_comb begin
    arm_acc  = arm && !stop && (state_q == ST_IDLE || state_q == ST_DONE);
    trig_hit = (state_q == ST_ARMED) && !stop && pc_event && (pc_in == trig_pc);
    wr_req   = pc_event && ((state_q == ST_CAPTURE) || trig_hit);
  end

  always_comb begin
    cap_cnt_d  = cap_cnt_q;
    overflow_d = overflow_q;
    if (arm_acc) begin
      cap_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok && cap_cnt_q != DEPTH_C) cap_cnt_d = cap_next;
      if (wr_req && !push_ok)               overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      cap_cnt_q  <= cap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (wr_req),
    .push_dat_i (entry),
    .pop_i      (rd_ready),
    .pop_dat_o  (rd_data),
    .push_ok_o  (push_ok),
    .empty_o    (fifo_empty),
    .count_o    (count)
  );

  assign rd_valid = !fifo_empty;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a behavioural model queues expected entries on
// recorded PC changes and compares them as the DUT pops them; spot checks cover the scenarios.
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pc_in;
  logic [13:0] ir_in;
  logic [7:0]  a_in, b_in;
  logic        z_in, c_in;
  logic        arm, stop, trig_en, one_shot, rd_ready;
  logic [9:0]  trig_pc;
  logic        rd_valid;
  logic [41:0] rd_data;
  logic [4:0]  count;
  logic        overflow;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [41:0] sb[$];
  int          m_state = 0;
  int          m_cap   = 0;
  bit          m_ovf   = 1'b0;
  bit          m_pcv   = 1'b0;
  logic [9:0]  m_pcq   = '0;

  always #5 clk = ~clk;

  cpu_trace_buffer dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ir_in(ir_in), .a_in(a_in), .b_in(b_in),
    .z_in(z_in), .c_in(c_in), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .one_shot(one_shot), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .count(count), .overflow(overflow), .state(state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pc(input logic [9:0] p);
    pc_in = p;
    ir_in = 14'($urandom);
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    z_in  = 1'($urandom_range(0, 1));
    c_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!rd_valid) break;
      tick();
    end
    check("drain_empty", rd_valid, 0);
    rd_ready = 1'b0;
  endtask

  // Reference model: compare DUT against the model state, then advance the model.
  always @(negedge clk) begin : mon
    bit ev, pop, arm_ok, trig, wr, full, ok;
    if (mon_en) begin
      check("state", state, m_state);
      check("count", count, sb.size());
      check("overflow", overflow, m_ovf);
      check("rd_valid", rd_valid, sb.size() != 0);
      if (sb.size() != 0) check("rd_data", rd_data, sb[0]);

      if (rst) begin
        sb.delete();
        m_state = 0; m_cap = 0; m_ovf = 0; m_pcv = 0; m_pcq = '0;
      end else begin
        ev     = m_pcv && (pc_in != m_pcq);
        pop    = (sb.size() != 0) && rd_ready;
        arm_ok = arm && !stop && (m_state == 0 || m_state == 3);
        trig   = (m_state == 1) && !stop && ev && (pc_in == trig_pc);
        wr     = ev && (m_state == 2 || trig);
        full   = (sb.size() == 16);
        ok     = wr && (!full || pop);
        if (pop) void'(sb.pop_front());
        if (ok)  sb.push_back({pc_in, ir_in, a_in, b_in, z_in, c_in});
        if (arm_ok) begin
          m_cap = 0;
          m_ovf = 0;
        end else begin
          if (ok && m_cap < 16) m_cap++;
          if (wr && !ok) m_ovf = 1;
        end
        case (m_state)
          0, 3: if (arm_ok) m_state = trig_en ? 1 : 2;
          1: if (stop) m_state = 3; else if (trig) m_state = 2;
          default: if (stop || (one_shot && ok && m_cap == 16)) m_state = 3;
        endcase
        m_pcq = pc_in;
        m_pcv = 1;
      end
    end
  end

  initial begin
    rst = 1'b1; arm = 0; stop = 0; trig_en = 0; trig_pc = '0; one_shot = 0; rd_ready = 0;
    drive_pc(10'd0);
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Free-running PC, immediate capture, arm while PC=5.
    for (int i = 0; i < 10; i++) begin
      drive_pc(10'(i));
      arm = (i == 5);
      tick();
      if (i == 5) check("t1_pre_vld", rd_valid, 0);
      if (i == 6) begin
        check("t1_first_vld", rd_valid, 1);
        check("t1_first_pc", rd_data[PC_LSB +: PC_W_DEF], 6);
      end
    end
    arm = 1'b0;
    check("t1_count", count, 4);
    pulse_stop();
    drain();

    // Trigger at PC 0x005 during a 0..9 sweep.
    drive_pc(10'd20);
    trig_en = 1'b1; trig_pc = 10'h005;
    pulse_arm();
    check("t2_armed", state, 1);
    for (int i = 0; i < 10; i++) begin
      drive_pc(10'(i));
      tick();
      if (i == 4) check("t2_no_pre", rd_valid, 0);
    end
    check("t2_state", state, 2);
    check("t2_count", count, 5);
    check("t2_first_pc", rd_data[PC_LSB +: PC_W_DEF], 5);
    pulse_stop();
    drain();

    // One-shot, no reads, 20 PC changes.
    trig_en = 1'b0; one_shot = 1'b1;
    pulse_arm();
    for (int k = 0; k < 20; k++) begin
      drive_pc(10'(100 + k));
      tick();
      if (k == 14) check("t3_not_done", state, 2);
      if (k == 15) begin
        check("t3_done", state, 3);
        check("t3_count16", count, 16);
      end
    end
    check("t3_count_end", count, 16);
    check("t3_no_ovf", overflow, 0);
    drain();

    // Continuous, no reads, 18 PC changes; then pop+push while full.
    one_shot = 1'b0;
    pulse_arm();
    for (int k = 0; k < 18; k++) begin
      drive_pc(10'(200 + k));
      tick();
    end
    check("t4_count", count, 16);
    check("t4_ovf", overflow, 1);
    check("t4_head_pc", rd_data[PC_LSB +: PC_W_DEF], 200);
    rd_ready = 1'b1;
    drive_pc(10'd250);
    tick();
    rd_ready = 1'b0;
    check("t4_full_pop_push", count, 16);
    pulse_stop();
    drain();

    // Random backpressure during capture.
    pulse_arm();
    for (int k = 0; k < 30; k++) begin
      drive_pc(10'(300 + k));
      rd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rd_ready = 1'b0;
    pulse_stop();
    drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_empty_ready", count, 0);
    end
    rd_ready = 1'b0;

    // Reset mid-capture with 7 entries.
    pulse_arm();
    for (int k = 0; k < 7; k++) begin
      drive_pc(10'(400 + k));
      tick();
    end
    check("t6_count7", count, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_state", state, 0);
    check("t6_count", count, 0);
    check("t6_rd_valid", rd_valid, 0);
    check("t6_overflow", overflow, 0);
    drive_pc(10'd500);
    tick();
    check("t6_no_rec", count, 0);
    tick();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Execution-trace recorder that sits directly downstream of `cpu_v1`. It consumes the core's architectural outputs (PC, IR, A, B, Z, C) and writes one 42-bit snapshot into an internal FIFO each time the PC changes, i.e. once per executed instruction. Capture can optionally start on a PC trigger. The buffered entries drain through a valid/ready read port to a debug host or a bench checker.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `PC_W`, 10: PC width.
- `IR_W`, 14: instruction width.
- `D_W`, 8: accumulator/register width.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_in` in PC_W: core PC (`PCout`).
- `ir_in` in IR_W: core IR (`IRout`).
- `a_in`, `b_in` in D_W: core A/B (`Aout`/`Bout`).
- `z_in`, `c_in` in 1: core flags (`Zout`/`Cout`).
- `arm` in 1: start-capture pulse.
- `stop` in 1: end-capture pulse.
- `trig_en` in 1: 1 = wait for `trig_pc` before capturing; 0 = capture immediately.
- `trig_pc` in PC_W: trigger address.
- `one_shot` in 1: 1 = stop after DEPTH entries; 0 = continuous.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ready` in 1: host accepts `rd_data`.
- `rd_data` out 42: entry = {pc[41:32], ir[31:18], a[17:10], b[9:2], z[1], c[0]}.
- `count` out clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag; at least one entry was dropped.
- `state` out 2: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

## Operation
- `pc_q`/`pc_q_vld` register `pc_in` every cycle in every state. `pc_q_vld` is 0 in reset and 1 from the first cycle after.
- Event in cycle t: `pc_q_vld && pc_in != pc_q`. The snapshot is the cycle-t input values.
- FSM:
  - IDLE --arm--> ARMED if `trig_en`, else CAPTURE.
  - ARMED --event with `pc_in==trig_pc`--> CAPTURE. The trigger event itself is recorded.
  - CAPTURE --stop, or (`one_shot` and `cap_cnt==DEPTH` after this write)--> DONE.
  - ARMED --stop--> DONE.
  - DONE --arm--> same as from IDLE.
  - `arm` in ARMED/CAPTURE is ignored. `stop` in IDLE/DONE is ignored. `stop` and `arm` in the same cycle: `stop` wins.
- Accepted `arm` clears `cap_cnt` and `overflow`. It does not flush the FIFO.
- Writes occur only in CAPTURE, plus the trigger cycle in ARMED.
- Push when full:
  - Without a simultaneous pop: entry dropped, `overflow`←1, `cap_cnt` not incremented.
  - With a simultaneous pop (`rd_valid && rd_ready`): push accepted, `count` unchanged.
- Pop: `rd_valid && rd_ready`. When empty, `rd_ready` is ignored.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.

## Timing
- Reset values: `state`=IDLE, `count`=0, `rd_valid`=0, `overflow`=0, pointers=0, `cap_cnt`=0, `pc_q_vld`=0.
- `rd_data` is X/don't-care while empty. The bench must not check it.
- Write latency: an event in cycle t makes the entry visible at t+1. From empty, `rd_valid` rises at t+1.
- `rd_data` is first-word-fall-through: it shows `mem[rd_ptr]` combinationally from the array, with no read latency.
- `state`, `count`, `overflow` are registered and update at the end of the cycle that causes them.
- `rst` asserted mid-capture or mid-drain: everything returns to reset values at the next edge. FIFO contents are discarded (pointers zeroed).

## Structure
- Package `cpu_trace_pkg`: state encoding localparams, field widths, entry width (42), field bit offsets.
- Sub-module `trace_fifo`:
  - Parameterised width/depth FIFO, synchronous with FWFT read.
  - Push/pop/full/empty/count, with full-with-pop accept.
- Top level holds the event detector, FSM, `cap_cnt`, overflow and entry packing.

## Test plan
- Free-running core PC 0→1→2, `trig_en`=0, arm at cycle 5 → exactly one entry per PC change. First entry has pc=next PC after arm, `rd_valid` one cycle after the event, fields match the inputs bit-exactly.
- `trig_en`=1, `trig_pc`=0x005, PC sweeps 0..9 → first entry pc=0x005. Nothing is recorded for PCs 0..4.
- `one_shot`=1, DEPTH=16, no reads, 20 PC changes → `count`=16, state=DONE after the 16th write, `overflow`=0.
- `one_shot`=0, no reads, 18 PC changes → `count`=16, `overflow`=1, FIFO holds the first 16 entries. A pop plus push while full keeps `count`=16.
- `rd_ready` toggling 50% during capture → entries drain in PC order with no duplicates or losses. With `rd_ready`=1 while empty, `count` stays 0.
- `rst` pulse mid-CAPTURE with `count`=7 → next cycle state=IDLE, `count`=0, `rd_valid`=0, `overflow`=0. No event is recorded on the first PC change after reset.
